// File: rtl/timed_step_sequencer.sv
// timed_step_sequencer
// Replays a programmed list of timed register writes. Each step waits its
// programmed delay, then writes reg_a, writes reg_b, increments count, or
// does nothing. Every step takes delay+3 cycles: LOAD, WAIT (delay+1), FIRE.
//
// Ports:
//   clock, reset_n          - clock; asynchronous active-low reset
//   prog_we/addr/delay/
//   prog_target/data/last   - program write port, accepted only in IDLE
//   start                   - begin at step 0, sampled only in IDLE
//   abort                   - synchronous cancel, highest priority
//   busy, done              - busy outside IDLE; one-cycle completion pulse
//   step_idx                - index of the step being executed
//   reg_a_q, reg_b_q,
//   count_q                 - datapath registers, kept across runs
module timed_step_sequencer #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 3,
    parameter int DELAY_W = 8,
    parameter int DATA_W  = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [DELAY_W-1:0] prog_delay,
    input  logic [1:0]         prog_target,
    input  logic [DATA_W-1:0]  prog_data,
    input  logic               prog_last,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  step_idx,
    output logic [DATA_W-1:0]  reg_a_q,
    output logic [DATA_W-1:0]  reg_b_q,
    output logic [DATA_W-1:0]  count_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_FIRE,
        S_DONE
    } state_t;

    localparam logic [1:0] TGT_A     = 2'd0;
    localparam logic [1:0] TGT_B     = 2'd1;
    localparam logic [1:0] TGT_COUNT = 2'd2;
    localparam logic [1:0] TGT_NOP   = 2'd3;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   step_q, step_d;
    logic [DELAY_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0]   reg_a_d, reg_b_d, count_d;

    // Flop-based program memory, read combinationally at step_q.
    logic [DELAY_W-1:0]  delay_q  [DEPTH];
    logic [DELAY_W-1:0]  delay_d  [DEPTH];
    logic [1:0]          target_q [DEPTH];
    logic [1:0]          target_d [DEPTH];
    logic [DATA_W-1:0]   data_q   [DEPTH];
    logic [DATA_W-1:0]   data_d   [DEPTH];
    logic                last_q   [DEPTH];
    logic                last_d   [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            timer_q <= '0;
            reg_a_q <= '0;
            reg_b_q <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                delay_q[i]  <= '0;
                target_q[i] <= TGT_NOP;
                data_q[i]   <= '0;
                last_q[i]   <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            timer_q <= timer_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            count_q <= count_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                delay_q[i]  <= delay_d[i];
                target_q[i] <= target_d[i];
                data_q[i]   <= data_d[i];
                last_q[i]   <= last_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        timer_d = timer_q;
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        count_d = count_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            delay_d[i]  = delay_q[i];
            target_d[i] = target_q[i];
            data_d[i]   = data_q[i];
            last_d[i]   = last_q[i];
        end

        // Program writes land even when start is sampled in the same cycle;
        // LOAD reads the entry one edge later, so the new entry is used.
        if (state_q == S_IDLE && prog_we) begin
            delay_d[prog_addr]  = prog_delay;
            target_d[prog_addr] = prog_target;
            data_d[prog_addr]   = prog_data;
            last_d[prog_addr]   = prog_last;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    step_d  = '0;
                end
            end
            S_LOAD: begin
                timer_d = delay_q[step_q];
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (timer_q == '0) state_d = S_FIRE;
                else               timer_d = timer_q - DELAY_W'(1);
            end
            S_FIRE: begin
                case (target_q[step_q])
                    TGT_A:     reg_a_d = data_q[step_q];
                    TGT_B:     reg_b_d = data_q[step_q];
                    TGT_COUNT: count_d = count_q + DATA_W'(1);
                    default:   ;
                endcase
                if (last_q[step_q] || step_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + ADDR_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                step_d  = '0;
            end
        endcase

        // Abort overrides everything above, including a pending FIRE write.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            step_d  = '0;
            reg_a_d = reg_a_q;
            reg_b_d = reg_b_q;
            count_d = count_q;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign step_idx = step_q;

endmodule

// File: doc/timed_step_sequencer.md
# timed_step_sequencer

Hardware sequencer that replays a small programmed list of timed register writes, modelled on behavioural stimulus of the form "after N time units, assign value V to register R". It owns three datapath registers: `reg_a`, `reg_b` and a `count` accumulator. A host programs up to DEPTH steps, pulses `start`, and the block walks the steps in order, waiting a per-step cycle delay before each write. It sits between a test/configuration master and the datapath registers it sequences.

## Interface
- DEPTH, 8, number of program steps (power of two, ≥2)
- ADDR_W, 3, step address width, equal to log2(DEPTH)
- DELAY_W, 8, per-step delay width
- DATA_W, 16, datapath register width

- clock  in  1  rising-edge clock, sole clock domain
- reset_n  in  1  asynchronous active-low reset
- prog_we  in  1  write one program entry; ignored while busy
- prog_addr  in  ADDR_W  program entry index
- prog_delay  in  DELAY_W  cycles to wait before the write
- prog_target  in  2  0=reg_a, 1=reg_b, 2=count increment, 3=no-op
- prog_data  in  DATA_W  write value; ignored for targets 2 and 3
- prog_last  in  1  entry is the final step
- start  in  1  begin execution at step 0; sampled only in IDLE
- abort  in  1  synchronous cancel; highest priority
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal completion
- step_idx  out  ADDR_W  index of the current step
- reg_a_q, reg_b_q, count_q  out  DATA_W each  datapath registers

## Operation
- FSM states: IDLE, LOAD, WAIT, FIRE, DONE.
- **IDLE:** `start`=1 moves to LOAD, with `step_idx`=0.
- **LOAD:** timer ← `delay[step_idx]`; move to WAIT.
- **WAIT:** if timer==0, move to FIRE; otherwise decrement timer.
- **FIRE:** perform the entry's action on the exiting edge.
  - target 0: `reg_a_q` ← data.
  - target 1: `reg_b_q` ← data.
  - target 2: `count_q` ← `count_q`+1, modulo 2^DATA_W; the maximum value wraps to 0.
  - target 3: nothing.
- FIRE exit: go to DONE if the entry's last=1 or `step_idx`==DEPTH-1. Otherwise increment `step_idx` and go to LOAD.
- **DONE:** `done`=1 for one cycle, then go to IDLE with `step_idx`←0.
- **abort=1** in any non-IDLE state:
  - next state is IDLE and `step_idx`←0;
  - any pending FIRE write is suppressed;
  - no `done` pulse;
  - datapath registers keep their values.
- Program memory is flop-based: one write port, combinational read at `step_idx`.
- Datapath registers are never cleared by `start`; they accumulate across runs.

## Timing
- Reset (async assert, sync deassert by the environment) sets:
  - state IDLE; `busy`=0, `done`=0, `step_idx`=0;
  - all `*_q`=0;
  - all program entries to {delay 0, target 3, last 0}.
- Step cost is D+3 cycles: LOAD 1, WAIT D+1, FIRE 1.
- Let `start` be sampled at edge E0 in IDLE:
  - the step-0 write is visible after edge E0+D0+3;
  - each later step k is visible D_k+3 edges after the previous write.
- After the last write edge, `done` is high for exactly one cycle. `busy` falls on the following edge.
- `prog_we` and `start` are ignored while `busy`=1. A program write and `start` in the same IDLE cycle: the write lands and execution uses the new entry.
- An unprogrammed run executes DEPTH no-op steps and completes after 3·DEPTH edges.

## Test plan
- **Two-step program.** Step0 {D=4, reg_a, 0x00A5, last 0}, step1 {D=2, reg_b, 0x1234, last 1}; `start` at E0 → `reg_a_q`=0x00A5 after E7, `reg_b_q`=0x1234 after E12, `done` high E12–E13, `busy` low after E13.
- **Count steps.** Three steps {D=0, target 2}, last on step 2 → `count_q` = 1, 2, 3 after E3, E6, E9; one `done` pulse.
- **Full depth, no last.** DEPTH=8 no-ops, D=0 → `step_idx` reaches 7, `done` after E24, `step_idx` returns to 0.
- **Abort mid-WAIT.** Step0 {D=10, reg_a, 0xBEEF}; `abort` at E5 → `busy`=0 after E5, `reg_a_q` unchanged at 0, no `done`. Also pulse `prog_we` and `start` while busy: both have no effect.
- **Reset mid-run.** `reset_n` low during WAIT → all outputs 0 immediately, without a clock edge. A following `start` runs the cleared no-op program and touches no registers.
- **Count wrap.** DATA_W=4, 8 increment steps run twice → `count_q`=8 after run 1, 0 after run 2.
